// File: rtl/rv32i_interrupt_ctrl.sv
// rtl/rv32i_interrupt_ctrl.sv - parametrised fixed-priority interrupt controller for the rv32i core
module rv32i_interrupt_ctrl #(
    parameter int unsigned          XLEN         = 32,
    parameter int unsigned          INT_COUNT    = 8,
    parameter int unsigned          ID_W         = (INT_COUNT > 1) ? $clog2(INT_COUNT) : 1,
    parameter logic [INT_COUNT-1:0] EDGE_MASK    = {INT_COUNT{1'b0}},
    parameter logic [INT_COUNT-1:0] MASK_RESET   = {INT_COUNT{1'b0}},
    parameter int unsigned          OFFSET_SHIFT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INT_COUNT-1:0] irq_i,
    input  logic [INT_COUNT-1:0] mask_i,
    input  logic                 mask_write_i,
    output logic [INT_COUNT-1:0] mask_o,
    input  logic                 global_enable_i,
    output logic [INT_COUNT-1:0] pending_o,
    output logic [INT_COUNT-1:0] active_o,
    output logic [ID_W-1:0]      active_id_o,
    output logic [XLEN-1:0]      vector_offset_o,
    output logic [1:0]           state_o,
    input  logic                 advance_i,
    input  logic                 clear_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [INT_COUNT-1:0]   irq_q;
    logic [INT_COUNT-1:0]   mask_q, mask_d;
    logic [INT_COUNT-1:0]   pending_q, pending_d;
    logic [INT_COUNT-1:0]   active_q, active_d;
    logic [ID_W-1:0]        active_id_q, active_id_d;
    logic [XLEN-1:0]        offset_q, offset_d;

    logic [INT_COUNT-1:0]   trigger;
    logic [INT_COUNT-1:0]   retire;
    logic [INT_COUNT-1:0]   eligible;
    logic [INT_COUNT-1:0]   select;
    logic [ID_W-1:0]        select_id;

    always_comb begin
        trigger   = (EDGE_MASK & irq_i & ~irq_q) | (~EDGE_MASK & irq_i);
        retire    = (state_q == ACTIVE && clear_i) ? active_q : '0;
        // Set is ORed after the retire so a line re-asserting during clear stays pending.
        pending_d = (pending_q & ~retire) | (trigger & mask_q);
        mask_d    = mask_write_i ? mask_i : mask_q;
        eligible  = pending_q & mask_q;
        select    = eligible & (~eligible + 1'b1);
        select_id = '0;
        for (int i = INT_COUNT - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                select_id = ID_W'(i);
            end
        end
        // Slot 0 of the vector table is the exception entry, so line n maps to slot n+1.
        offset_d = (|active_q) ? ((XLEN'(active_id_q) + XLEN'(1)) << OFFSET_SHIFT) : '0;
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        active_id_d = active_id_q;
        case (state_q)
            IDLE: begin
                if (global_enable_i && (|eligible)) begin
                    active_d    = select;
                    active_id_d = select_id;
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                if (advance_i) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (clear_i) begin
                    active_d    = '0;
                    active_id_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                active_d    = '0;
                active_id_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            mask_q      <= MASK_RESET;
            pending_q   <= '0;
            active_q    <= '0;
            active_id_q <= '0;
            offset_q    <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_i;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            active_id_q <= active_id_d;
            offset_q    <= offset_d;
        end
    end

    assign mask_o          = mask_q;
    assign pending_o       = pending_q;
    assign active_o        = active_q;
    assign active_id_o     = active_id_q;
    assign vector_offset_o = offset_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_rv32i_interrupt_ctrl.sv
// tb/tb_rv32i_interrupt_ctrl.sv - directed and randomized bench with a behavioural reference model
module tb_rv32i_interrupt_ctrl;

    localparam logic [7:0] EDGE  = 8'h02;
    localparam logic [7:0] MRST  = 8'hC3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq = 8'h00;
    logic [7:0]  mask_in = 8'h00;
    logic        mask_wr = 1'b0;
    logic        en = 1'b0;
    logic        adv = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  mask_o, pending_o, active_o;
    logic [2:0]  active_id_o;
    logic [31:0] offset_o;
    logic [1:0]  state_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: state as a plain number, active line as an integer index (-1 = none).
    int          m_state;
    int          m_id;
    int          m_off;
    logic [7:0]  m_pend, m_mask, m_prev;

    rv32i_interrupt_ctrl #(
        .XLEN(32), .INT_COUNT(8), .EDGE_MASK(EDGE), .MASK_RESET(MRST), .OFFSET_SHIFT(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .mask_i(mask_in), .mask_write_i(mask_wr),
        .mask_o(mask_o), .global_enable_i(en), .pending_o(pending_o), .active_o(active_o),
        .active_id_o(active_id_o), .vector_offset_o(offset_o), .state_o(state_o),
        .advance_i(adv), .clear_i(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] trig;
        logic [7:0] ret;
        logic [7:0] elig;
        int n_state, n_id, n_off;
        for (int i = 0; i < 8; i++)
            trig[i] = EDGE[i] ? (irq[i] & ~m_prev[i]) : irq[i];
        ret   = (m_state == 2 && clr) ? (8'h01 << m_id) : 8'h00;
        n_off = (m_id >= 0) ? (m_id + 1) * 4 : 0;
        n_state = m_state;
        n_id    = m_id;
        elig    = m_pend & m_mask;
        if (m_state == 0) begin
            if (en && elig != 0) begin
                for (int i = 7; i >= 0; i--) if (elig[i]) n_id = i;
                n_state = 1;
            end
        end else if (m_state == 1) begin
            if (adv) n_state = 2;
        end else if (m_state == 2) begin
            if (clr) begin n_state = 0; n_id = -1; end
        end
        if (rst) begin
            m_state = 0; m_id = -1; m_off = 0;
            m_pend = 8'h00; m_mask = MRST; m_prev = 8'h00;
        end else begin
            m_pend  = (m_pend & ~ret) | (trig & m_mask);
            m_mask  = mask_wr ? mask_in : m_mask;
            m_prev  = irq;
            m_state = n_state;
            m_id    = n_id;
            m_off   = n_off;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("state",   32'(state_o),     m_state);
        check("pending", 32'(pending_o),   32'(m_pend));
        check("mask",    32'(mask_o),      32'(m_mask));
        check("active",  32'(active_o),    (m_id >= 0) ? (32'd1 << m_id) : 32'd0);
        check("id",      32'(active_id_o), (m_id >= 0) ? m_id : 0);
        check("offset",  offset_o,         m_off);
    endtask

    initial begin
        m_state = 0; m_id = -1; m_off = 0;
        m_pend = 8'h00; m_mask = MRST; m_prev = 8'h00;

        tick(); tick();
        check("rst_mask", 32'(mask_o), 32'hC3);
        rst = 1'b0;

        // Level line 3 timing
        mask_wr = 1'b1; mask_in = 8'hFF; en = 1'b1; tick();
        mask_wr = 1'b0; irq = 8'h08; tick();
        check("t1_pending", 32'(pending_o), 32'h08);
        tick();
        check("t1_state", 32'(state_o), 32'd1);
        check("t1_active", 32'(active_o), 32'h08);
        check("t1_id", 32'(active_id_o), 32'd3);
        tick();
        check("t1_offset", offset_o, 32'h10);
        irq = 8'h00; adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;

        // Simultaneous lines 2 and 5
        irq = 8'h24; tick();
        irq = 8'h00; tick();
        check("t2_active", 32'(active_o), 32'h04);
        tick();
        check("t2_offset", offset_o, 32'h0C);
        adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0; tick();
        check("t2_id5", 32'(active_id_o), 32'd5);
        tick();
        check("t2_offset5", offset_o, 32'h18);
        adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;

        // Edge line 1 held high
        irq = 8'h02;
        for (int k = 0; k < 10; k++) begin
            adv = (k == 2);
            clr = (k == 3);
            tick();
        end
        adv = 1'b0; clr = 1'b0;
        check("t3_no_reclaim_state", 32'(state_o), 32'd0);
        check("t3_no_reclaim_pend", 32'(pending_o), 32'h00);
        irq = 8'h00; tick();
        irq = 8'h02; tick();
        check("t3_rearm", 32'(pending_o), 32'h02);
        irq = 8'h00; tick();
        adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;

        // Masking keeps the pending bit but blocks the claim
        en = 1'b0; irq = 8'h10; tick();
        irq = 8'h00; mask_wr = 1'b1; mask_in = 8'h00; tick();
        mask_wr = 1'b0; en = 1'b1; tick(); tick(); tick();
        check("t4_state", 32'(state_o), 32'd0);
        check("t4_pend", 32'(pending_o), 32'h10);
        mask_wr = 1'b1; mask_in = 8'h10; tick();
        mask_wr = 1'b0; tick();
        check("t4_claim", 32'(active_o), 32'h10);
        adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0; mask_wr = 1'b1; mask_in = 8'hFF; tick();
        mask_wr = 1'b0;

        // Re-assert during clear, then global enable gating
        irq = 8'h01; tick(); tick();
        adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        check("t5_idle", 32'(state_o), 32'd0);
        check("t5_pend0", 32'(pending_o[0]), 32'd1);
        clr = 1'b0; en = 1'b0; tick(); tick(); tick();
        check("t5_gated", 32'(state_o), 32'd0);
        en = 1'b1; tick();
        check("t5_reclaim", 32'(state_o), 32'd1);
        irq = 8'h00; adv = 1'b1; tick();
        adv = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            irq     = 8'($urandom);
            en      = ($urandom % 8) != 0;
            mask_wr = ($urandom % 16) == 0;
            mask_in = 8'($urandom);
            adv     = ($urandom % 3) == 0;
            clr     = ($urandom % 3) == 0;
            rst     = ($urandom % 200) == 0;
            tick();
        end
        irq = 8'h00; mask_wr = 1'b0; adv = 1'b0; clr = 1'b0; en = 1'b1;
        rst = 1'b1; tick();
        rst = 1'b0;

        // Reset in the middle of a handshake
        mask_wr = 1'b1; mask_in = 8'hFF; tick();
        mask_wr = 1'b0; irq = 8'h01;
        for (int k = 0; k < 10 && state_o != 2'd1; k++) tick();
        check("reach_request", 32'(state_o), 32'd1);
        rst = 1'b1; tick();
        check("t6_state", 32'(state_o), 32'd0);
        check("t6_active", 32'(active_o), 32'h00);
        check("t6_pend", 32'(pending_o), 32'h00);
        check("t6_offset", offset_o, 32'h0);
        check("t6_mask", 32'(mask_o), 32'hC3);
        rst = 1'b0; irq = 8'h00; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
